// File: rtl/llc_input_scheduler_pkg.sv
// rtl/llc_input_scheduler_pkg.sv - shared types and constants for the LLC input scheduler
package llc_input_scheduler_pkg;

  localparam int LLC_N_MSHR = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    PROCESS = 2'd2
  } llc_sched_state_t;

  typedef struct packed {
    logic dma;
    logic req;
    logic replay;
    logic rsp;
  } llc_src_t;

  // Fixed priority rsp > replay > req > dma, overridden by a starving req.
  function automatic llc_src_t pick_src(input llc_src_t elig, input logic force_req);
    llc_src_t w;
    w = '0;
    if (force_req)       w.req    = 1'b1;
    else if (elig.rsp)    w.rsp    = 1'b1;
    else if (elig.replay) w.replay = 1'b1;
    else if (elig.req)    w.req    = 1'b1;
    else if (elig.dma)    w.dma    = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/llc_mshr_counter.sv
// rtl/llc_mshr_counter.sv - free-MSHR up/down counter with sticky over/underflow flag
module llc_mshr_counter
  import llc_input_scheduler_pkg::*;
#(
  parameter int N_MSHR = LLC_N_MSHR,
  parameter int CNT_W  = $clog2(N_MSHR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc,
  input  logic             free,
  output logic [CNT_W-1:0] cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(N_MSHR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= FULL;
      err <= 1'b0;
    end else begin
      // Simultaneous alloc and free cancel; an out-of-range step holds and flags.
      case ({alloc, free})
        2'b10: begin
          if (cnt == '0) err <= 1'b1;
          else           cnt <= cnt - CNT_W'(1);
        end
        2'b01: begin
          if (cnt == FULL) err <= 1'b1;
          else             cnt <= cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/llc_input_scheduler.sv
// rtl/llc_input_scheduler.sv - LLC front-end source arbiter, transaction sequencer and MSHR gate
module llc_input_scheduler
  import llc_input_scheduler_pkg::*;
#(
  parameter int N_MSHR     = LLC_N_MSHR,
  parameter int STARVE_MAX = 8,
  parameter int CNT_W      = $clog2(N_MSHR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rsp_valid,
  input  logic             replay_valid,
  input  logic             req_valid,
  input  logic             dma_valid,
  input  logic             evict_stall,
  input  logic             mshr_alloc,
  input  logic             mshr_free,
  input  logic             proc_done,
  output logic             decode_en,
  output logic             grant_rsp,
  output logic             grant_replay,
  output logic             grant_req,
  output logic             grant_dma,
  output logic [CNT_W-1:0] mshr_cnt,
  output logic             busy,
  output logic             mshr_err
);

  localparam int               STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0]    FULL       = CNT_W'(N_MSHR);

  llc_sched_state_t    state, state_d;
  llc_src_t            grant, grant_d;
  llc_src_t            elig, winner;
  logic [STARVE_W-1:0] starve_cnt, starve_d;
  logic                force_req;

  llc_mshr_counter #(
    .N_MSHR (N_MSHR),
    .CNT_W  (CNT_W)
  ) u_mshr_counter (
    .clk   (clk),
    .rst   (rst),
    .alloc (mshr_alloc),
    .free  (mshr_free),
    .cnt   (mshr_cnt),
    .err   (mshr_err)
  );

  always_comb begin
    elig        = '0;
    elig.rsp    = rsp_valid && (mshr_cnt != FULL);
    elig.replay = replay_valid && !evict_stall;
    elig.req    = req_valid && (mshr_cnt != '0) && !evict_stall;
    elig.dma    = dma_valid && (mshr_cnt != '0) && !evict_stall;
    force_req   = (starve_cnt == STARVE_TOP) && elig.req;
    winner      = pick_src(elig, force_req);
  end

  always_comb begin
    state_d  = state;
    grant_d  = grant;
    starve_d = starve_cnt;
    case (state)
      IDLE: begin
        if (|elig) begin
          grant_d = winner;
          state_d = DECODE;
          // Starvation only counts grants where req was actually eligible and lost.
          if (winner.req)
            starve_d = '0;
          else if (elig.req && (starve_cnt != STARVE_TOP))
            starve_d = starve_cnt + STARVE_W'(1);
        end
      end
      DECODE:  state_d = PROCESS;
      PROCESS: begin
        if (proc_done) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_d;
      grant      <= grant_d;
      starve_cnt <= starve_d;
    end
  end

  assign decode_en    = (state == DECODE);
  assign busy         = (state != IDLE);
  assign grant_rsp    = grant.rsp;
  assign grant_replay = grant.replay;
  assign grant_req    = grant.req;
  assign grant_dma    = grant.dma;

endmodule
